prog_clk_divider: RTL and testbench
===================================

// Module: prog_clk_divider
// PURPOSE
//  Multi-channel programmable clock divider / enable generator. Each channel
//  derives a toggling divided clock and a 1-cycle tick from the system clock.
//  Divisors are written at run time through a valid/ready port and applied
//  glitch-free at the channel's next terminal count.
//  Replaces fixed per-design dividers; feeds display refresh and audio/tone timing.
// PARAMETERS
//  N_CH     2      number of independent channels (1..8)
//  CW       16     counter/divisor width in bits
//  DEF_DIV  12500  half-period (in clk cycles) loaded into every channel at reset
// PORTS
//  clk       in   1                 system clock, rising edge
//  reset     in   1                 asynchronous, active-low; all state to reset values
//  en        in   N_CH              per-channel run enable
//  wr_valid  in   1                 divisor write request
//  wr_ch     in   max(1,clog2 N_CH) target channel
//  wr_div    in   CW                new half-period value
//  wr_ready  out  1                 write accepted this cycle when wr_valid&wr_ready
//  clk_out   out  N_CH              divided clocks, 50% duty, period = 2*div clk cycles
//  tick      out  N_CH              1-cycle pulse on each 0->1 transition of clk_out
//  pending   out  N_CH              shadow divisor waiting to be applied
// BEHAVIOUR
//  - Reset (reset=0): cnt=0, active_div=shadow_div=DEF_DIV, clk_out=0, tick=0,
//    pending=0. wr_ready is 1 during reset.
//  - Per channel, en=1, active_div>=1: cnt counts 0..active_div-1. At terminal
//    count (cnt==active_div-1): cnt<=0, clk_out<=~clk_out. tick<=1 for one cycle
//    exactly when clk_out goes 0->1 (same edge), else 0. All outputs are registered.
//  - First toggle of clk_out occurs active_div cycles after en rises.
//  - active_div==1: clk_out toggles every cycle (clk/2); tick high every 2nd cycle.
//  - active_div==0: channel parked: cnt=0, clk_out=0, tick=0.
//  - en=0: next edge cnt<=0, clk_out<=0, tick<=0; active_div/shadow kept.
//  - Write handshake: wr_ready = ~pending[wr_ch] (combinational from registered
//    state). On accept: shadow_div[wr_ch]<=wr_div, pending[wr_ch]<=1.
//    wr_ch>=N_CH: wr_ready=1, write is dropped, no state change.
//  - Apply: active_div<=shadow_div, pending<=0, cnt<=0 at the first terminal count
//    after the accept cycle; immediately (next edge) if en=0 or active_div==0.
//    clk_out toggles normally on that terminal count -> no runt or stretched
//    half-period beyond one old and one new half-period.
//  - Accept coinciding with a terminal count of the same channel: that terminal
//    count uses the old value; the new value is applied at the following one.
//  - Reset asserted mid-operation: immediate return to reset values; pending
//    writes lost.
//  - No arithmetic overflow: cnt compared against active_div-1 only when
//    active_div!=0; counter width CW.
// STRUCTURE
//  - Package prog_clk_div_pkg: CW default, DEF_DIV default, channel-index width
//    function, named constants for standard rates (e.g. DIV_DISPLAY=12500).
//  - Sub-module prog_clk_div_ch: one channel (cnt, active/shadow div, pending,
//    clk_out, tick); top instantiates N_CH copies via generate and decodes
//    write port/wr_ready mux.
// TESTING
//  1 Reset: hold reset=0 with en=all 1 -> clk_out=0, tick=0, pending=0, wr_ready=1;
//    release -> ch0 first toggle after 12500 cycles.
//  2 Write ch0 div=3, en0=1 -> after apply, clk_out0 period 6 cycles, tick0 every 6
//    cycles, duty 3/3.
//  3 ch0 div=5 running, write div=2 mid-half-period -> pending0=1, wr_ready for ch0=0,
//    second write to ch0 stalls; one 5-cycle half then 2-cycle halves, pending0 clears.
//  4 Write accepted same cycle as ch1 terminal count -> old half-period used once
//    more, new value from next terminal count.
//  5 div=1 -> clk_out toggles every cycle; div=0 -> clk_out=0, tick=0, applied next
//    edge; en=0 mid-count -> clk_out=0 next edge, restart after en=1.
//  6 wr_ch=N_CH (out of range) -> accepted, no channel changes; async reset pulsed
//    mid-count with pending write -> all reset values, pending lost.

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default counter width and reset divisor, named half-period
// constants for common rates (50 MHz system clock assumed), and the
// channel-index width helper used to size the write-channel port.
package prog_clk_div_pkg;

    localparam int CW_DEFAULT      = 16;
    localparam int DEF_DIV_DEFAULT = 12500;

    // Half-periods in system-clock cycles at 50 MHz.
    localparam int DIV_DISPLAY     = 12500;   // 2 kHz display refresh
    localparam int DIV_TONE_1KHZ   = 25000;   // 1 kHz tone
    localparam int DIV_TONE_2KHZ   = 12500;   // 2 kHz tone

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/prog_clk_div_ch.sv
// One divider channel: counter, active/shadow divisor, divided clock and tick.
// Latency: all outputs registered; first toggle active_div cycles after en rises.
// Backpressure: accepts a write only while no shadow divisor is pending.
//
// Ports:
//   i_clk      system clock          i_reset    async active-low reset
//   i_en       run enable            i_wr       write request for this channel
//   i_wr_div   new half-period       o_clk_out  divided clock, 50% duty
//   o_tick     1-cycle pulse on each rising o_clk_out
//   o_pending  shadow divisor waiting for the next terminal count
module prog_clk_div_ch #(
    parameter int CW      = 16,
    parameter int DEF_DIV = 12500
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    output logic          o_clk_out,
    output logic          o_tick,
    output logic          o_pending
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_active_div;
    logic [CW-1:0] r_shadow_div;
    logic          r_pending;
    logic          r_clk_out;
    logic          r_tick;

    logic w_parked;
    logic w_tc;
    logic w_apply;
    logic w_accept;

    // A zero divisor parks the channel; the subtraction below is only
    // meaningful when the divisor is non-zero, so it is masked by w_parked.
    assign w_parked = (r_active_div == '0);
    assign w_tc     = i_en && !w_parked && (r_cnt == r_active_div - CW'(1));

    // A pending divisor waits for a terminal count so the running half-period
    // completes; an idle or parked channel has no half-period to protect.
    // Because r_pending is registered, a terminal count in the accept cycle
    // itself still runs on the old divisor.
    assign w_apply  = r_pending && (w_tc || !i_en || w_parked);
    assign w_accept = i_wr && !r_pending;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt        <= '0;
            r_active_div <= CW'(DEF_DIV);
            r_shadow_div <= CW'(DEF_DIV);
            r_pending    <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (!i_en || w_parked) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
            end else if (w_tc) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= ~r_clk_out;   // pulse only on the 0->1 toggle
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Apply and accept are mutually exclusive: apply needs pending=1,
            // accept needs pending=0.
            if (w_apply) begin
                r_active_div <= r_shadow_div;
                r_pending    <= 1'b0;
                r_cnt        <= '0;
            end else if (w_accept) begin
                r_shadow_div <= i_wr_div;
                r_pending    <= 1'b1;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider / enable generator.
// Latency: outputs registered; a divisor write takes effect at the channel's next terminal count.
// Backpressure: wr_ready drops for a channel while it holds an unapplied divisor.
//
// Ports:
//   i_clk       system clock            i_reset     async active-low reset
//   i_en        per-channel run enable  i_wr_valid  divisor write request
//   i_wr_ch     target channel          i_wr_div    new half-period
//   o_wr_ready  write accepted when i_wr_valid & o_wr_ready
//   o_clk_out   divided clocks          o_tick      rising-edge pulses
//   o_pending   per-channel shadow divisor waiting
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter  int N_CH    = 2,
    parameter  int CW      = CW_DEFAULT,
    parameter  int DEF_DIV = DEF_DIV_DEFAULT,
    localparam int CHW     = ch_idx_w(N_CH)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_en,
    input  logic            i_wr_valid,
    input  logic [CHW-1:0]  i_wr_ch,
    input  logic [CW-1:0]   i_wr_div,
    output logic            o_wr_ready,
    output logic [N_CH-1:0] o_clk_out,
    output logic [N_CH-1:0] o_tick,
    output logic [N_CH-1:0] o_pending
);

    logic [N_CH-1:0] w_wr_sel;
    logic [N_CH-1:0] w_pending;
    logic            w_wr_ready;

    // Out-of-range channel numbers match no channel: ready stays high and the
    // write is silently dropped.
    always_comb begin
        w_wr_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (i_wr_ch == CHW'(i)) begin
                w_wr_ready = ~w_pending[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr_sel[g] = i_wr_valid && (i_wr_ch == CHW'(g));

        prog_clk_div_ch #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_en      (i_en[g]),
            .i_wr      (w_wr_sel[g]),
            .i_wr_div  (i_wr_div),
            .o_clk_out (o_clk_out[g]),
            .o_tick    (o_tick[g]),
            .o_pending (w_pending[g])
        );
    end

    assign o_wr_ready = w_wr_ready;
    assign o_pending  = w_pending;

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [NC-1:0] i_en;
    logic          i_wr_valid;
    logic [1:0]    i_wr_ch;
    logic [15:0]   i_wr_div;
    logic          o_wr_ready;
    logic [NC-1:0] o_clk_out;
    logic [NC-1:0] o_tick;
    logic [NC-1:0] o_pending;

    prog_clk_divider #(.N_CH(NC), .CW(16), .DEF_DIV(12500)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_wr_valid (i_wr_valid),
        .i_wr_ch    (i_wr_ch),
        .i_wr_div   (i_wr_div),
        .o_wr_ready (o_wr_ready),
        .o_clk_out  (o_clk_out),
        .o_tick     (o_tick),
        .o_pending  (o_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    // Expected clk_out edges per channel: cycle number and new level.
    typedef struct { int cyc; logic lvl; } ev_t;
    ev_t q [NC][$];

    task automatic exp_edge(input int ch, input int c, input logic lvl);
        ev_t e;
        e.cyc = c;
        e.lvl = lvl;
        q[ch].push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every clk_out change must match the head of the channel's
    // queue; tick must coincide exactly with rising clk_out.
    logic [NC-1:0] prev = '0;
    ev_t           m_e;
    logic          m_rise;
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            m_rise = o_clk_out[c] && !prev[c];
            if (o_clk_out[c] !== prev[c]) begin
                n_vec++;
                if (q[c].size() == 0) begin
                    n_err++;
                    $display("FAIL edge_ch%0d: got clk_out->%0b at cycle %0d, expected no edge",
                             c, o_clk_out[c], cyc);
                end else begin
                    m_e = q[c].pop_front();
                    if (m_e.cyc != cyc || m_e.lvl !== o_clk_out[c]) begin
                        n_err++;
                        $display("FAIL edge_ch%0d: got level %0b at cycle %0d, expected level %0b at cycle %0d",
                                 c, o_clk_out[c], cyc, m_e.lvl, m_e.cyc);
                    end
                end
            end
            if (o_tick[c] || m_rise) begin
                n_vec++;
                if (o_tick[c] !== m_rise) begin
                    n_err++;
                    $display("FAIL tick_ch%0d: got tick %0b expected %0b at cycle %0d",
                             c, o_tick[c], m_rise, cyc);
                end
            end
            prev[c] = o_clk_out[c];
        end
    end

    // Stimulus points sit 2 ns after a rising edge; cyc then names that edge.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Write with bounded wait for ready; returns 2 ns after the accepting edge.
    task automatic wr(input int ch, input int div);
        int n;
        i_wr_valid = 1'b1;
        i_wr_ch    = 2'(ch);
        i_wr_div   = 16'(div);
        for (n = 0; n < 50; n++) begin
            #1;
            if (o_wr_ready) break;
            @(posedge clk);
            #2;
        end
        if (n == 50) begin
            n_vec++;
            n_err++;
            $display("FAIL wr_timeout: ch %0d not ready after %0d cycles", ch, n);
        end else begin
            @(posedge clk);
            #2;
        end
        i_wr_valid = 1'b0;
    endtask

    int t;
    int t2;

    initial begin
        i_reset    = 1'b0;
        i_en       = '1;
        i_wr_valid = 1'b0;
        i_wr_ch    = '0;
        i_wr_div   = '0;

        // 1: reset state with all enables high, then default first toggle.
        goto(3);
        chk("rst_clk_out", int'(o_clk_out), 0);
        chk("rst_tick",    int'(o_tick),    0);
        chk("rst_pending", int'(o_pending), 0);
        chk("rst_wr_rdy",  int'(o_wr_ready), 1);
        t = cyc;
        for (int c = 0; c < NC; c++) exp_edge(c, t + 12500, 1'b1);
        i_reset = 1'b1;
        goto(t + 12500);
        i_en = '0;
        for (int c = 0; c < NC; c++) exp_edge(c, t + 12501, 1'b0);
        goto(t + 12502);

        // 2: ch0 div=3 -> 3/3 duty, 6-cycle period.
        wr(0, 3);
        chk("p2_pending_set", int'(o_pending[0]), 1);
        goto(cyc + 1);
        chk("p2_pending_clr", int'(o_pending[0]), 0);
        t = cyc;
        i_en[0] = 1'b1;
        exp_edge(0, t + 3, 1'b1);  exp_edge(0, t + 6, 1'b0);
        exp_edge(0, t + 9, 1'b1);  exp_edge(0, t + 12, 1'b0);
        exp_edge(0, t + 15, 1'b1); exp_edge(0, t + 18, 1'b0);
        goto(t + 18);
        i_en[0] = 1'b0;

        // 3: div=5 running, rewrite to 2 mid-half; second write stalls.
        wr(0, 5);
        goto(cyc + 1);
        t = cyc;
        i_en[0] = 1'b1;
        exp_edge(0, t + 5, 1'b1);  exp_edge(0, t + 10, 1'b0);
        exp_edge(0, t + 12, 1'b1); exp_edge(0, t + 14, 1'b0);
        exp_edge(0, t + 16, 1'b1); exp_edge(0, t + 18, 1'b0);
        goto(t + 7);
        wr(0, 2);
        chk("p3_pending_set", int'(o_pending[0]), 1);
        i_wr_valid = 1'b1; i_wr_ch = 2'd0; i_wr_div = 16'd7;
        #1;
        chk("p3_stall_a", int'(o_wr_ready), 0);
        @(posedge clk); #2;
        chk("p3_stall_b", int'(o_wr_ready), 0);
        i_wr_valid = 1'b0;
        goto(t + 10);
        chk("p3_pending_clr", int'(o_pending[0]), 0);
        goto(t + 18);
        i_en[0] = 1'b0;

        // 4: write to ch1 accepted on its terminal count.
        wr(1, 4);
        goto(cyc + 1);
        t = cyc;
        i_en[1] = 1'b1;
        exp_edge(1, t + 4, 1'b1);  exp_edge(1, t + 8, 1'b0);
        exp_edge(1, t + 12, 1'b1); exp_edge(1, t + 14, 1'b0);
        exp_edge(1, t + 16, 1'b1); exp_edge(1, t + 18, 1'b0);
        goto(t + 7);
        wr(1, 2);
        goto(t + 11);
        chk("p4_pending_hold", int'(o_pending[1]), 1);
        goto(t + 12);
        chk("p4_pending_clr", int'(o_pending[1]), 0);
        goto(t + 18);
        i_en[1] = 1'b0;

        // 5: div=1 (clk/2), then div=0 parks, then restart and en=0 mid-count.
        wr(0, 1);
        goto(cyc + 1);
        t = cyc;
        i_en[0] = 1'b1;
        exp_edge(0, t + 1, 1'b1); exp_edge(0, t + 2, 1'b0);
        exp_edge(0, t + 3, 1'b1); exp_edge(0, t + 4, 1'b0);
        exp_edge(0, t + 5, 1'b1); exp_edge(0, t + 6, 1'b0);
        goto(t + 4);
        wr(0, 0);
        goto(t + 8);
        chk("p5_park_clk",  int'(o_clk_out[0]), 0);
        chk("p5_park_tick", int'(o_tick[0]),    0);
        chk("p5_park_pend", int'(o_pending[0]), 0);
        goto(t + 20);
        t = cyc;
        exp_edge(0, t + 5, 1'b1);  exp_edge(0, t + 8, 1'b0);
        exp_edge(0, t + 11, 1'b1); exp_edge(0, t + 13, 1'b0);
        exp_edge(0, t + 18, 1'b1); exp_edge(0, t + 21, 1'b0);
        wr(0, 3);
        goto(t + 12);
        i_en[0] = 1'b0;
        goto(t + 15);
        i_en[0] = 1'b1;
        goto(t + 21);
        i_en[0] = 1'b0;

        // 6: out-of-range channel write is accepted and dropped.
        i_wr_valid = 1'b1; i_wr_ch = 2'd3; i_wr_div = 16'd9;
        #1;
        chk("p6_oor_ready", int'(o_wr_ready), 1);
        @(posedge clk); #2;
        i_wr_valid = 1'b0;
        chk("p6_oor_pending", int'(o_pending), 0);
        t = cyc;
        i_en = 3'b010;
        exp_edge(1, t + 2, 1'b1); exp_edge(1, t + 4, 1'b0);
        goto(t + 4);
        i_en = '0;

        // 6: reset mid-count with a pending write.
        goto(cyc + 2);
        t = cyc;
        i_en = 3'b001;
        exp_edge(0, t + 3, 1'b1);
        goto(t + 4);
        wr(0, 7);
        chk("p6_pend_before", int'(o_pending[0]), 1);
        exp_edge(0, t + 5, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("p6_rst_pending", int'(o_pending), 0);
        chk("p6_rst_clk",     int'(o_clk_out), 0);
        chk("p6_rst_tick",    int'(o_tick),    0);
        chk("p6_rst_ready",   int'(o_wr_ready), 1);
        goto(t + 7);
        t2 = cyc;
        i_reset = 1'b1;
        exp_edge(0, t2 + 12500, 1'b1);
        goto(t2 + 12500);
        i_en = '0;
        exp_edge(0, t2 + 12501, 1'b0);
        goto(t2 + 12506);

        for (int c = 0; c < NC; c++) chk($sformatf("leftover_ch%0d", c), q[c].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
